counter_sequencer: RTL and testbench

- Controller for the 8-bit toggle-flip-flop counter.
- Drives the counter's Enable and active-low synchronous clear, and observes its CounterValue.
- Provides start/stop control, a programmable rate divider (one count every Div+1 cycles) and a terminal-count limit, in one-shot or auto-reload mode.
- Sits between control logic (switches/keys or an upstream FSM) and the counter instance.

---
 rtl/counter_sequencer_if.sv | 28 ++
 rtl/counter_sequencer.sv | 95 +++++++++
 tb/tb_counter_sequencer.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/counter_sequencer_if.sv
// Control/status bundle between a counter_sequencer and its environment.
// The slave side is the sequencer; the master side is the upstream control plus the counter.
interface counter_sequencer_if #(
  parameter int unsigned DIV_W = 8,
  parameter int unsigned CNT_W = 8
) ();
  logic             Start;
  logic             Stop;
  logic             Mode;
  logic [DIV_W-1:0] Div;
  logic [CNT_W-1:0] Limit;
  logic [CNT_W-1:0] CounterValue;
  logic             CntEnable;
  logic             CntClear_b;
  logic             Busy;
  logic             Done;
  logic             Wrap;

  modport master (
    output Start, Stop, Mode, Div, Limit, CounterValue,
    input  CntEnable, CntClear_b, Busy, Done, Wrap
  );

  modport slave (
    input  Start, Stop, Mode, Div, Limit, CounterValue,
    output CntEnable, CntClear_b, Busy, Done, Wrap
  );
endinterface

// File: rtl/counter_sequencer.sv
// Start/stop sequencer for an external counter: clears it, paces increments through a
// rate divider and stops or reloads when the counter reaches a terminal count.
module counter_sequencer #(
  parameter int unsigned DIV_W = 8,
  parameter int unsigned CNT_W = 8
) (
  input logic               Clock,
  input logic               Reset,
  counter_sequencer_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StClear, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic             rst_flag_q, rst_flag_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             mode_q, mode_d;
  logic [DIV_W-1:0] div_lim_q, div_lim_d;
  logic [CNT_W-1:0] limit_q, limit_d;

  logic at_limit;
  logic div_hit;

  assign at_limit = (bus.CounterValue == limit_q);
  assign div_hit  = (div_q == div_lim_q);

  always_comb begin
    state_d    = state_q;
    rst_flag_d = rst_flag_q;
    div_d      = div_q;
    mode_d     = mode_q;
    div_lim_d  = div_lim_q;
    limit_d    = limit_q;
    unique case (state_q)
      StIdle: begin
        if (bus.Start && !bus.Stop) begin
          mode_d    = bus.Mode;
          div_lim_d = bus.Div;
          limit_d   = bus.Limit;
          state_d   = StClear;
        end
      end
      StClear: begin
        div_d      = '0;
        rst_flag_d = 1'b0;
        // The counter clear lands on this edge regardless of where we go next.
        state_d    = (rst_flag_q || bus.Stop) ? StIdle : StRun;
      end
      StRun: begin
        if (bus.Stop) begin
          state_d = StIdle;
          div_d   = '0;
        end else if (at_limit) begin
          state_d = mode_q ? StDone : StClear;
        end else begin
          div_d = div_hit ? '0 : div_q + DIV_W'(1);
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q    <= StClear;
      rst_flag_q <= 1'b1;
      div_q      <= '0;
      mode_q     <= 1'b0;
      div_lim_q  <= '0;
      limit_q    <= '0;
    end else begin
      state_q    <= state_d;
      rst_flag_q <= rst_flag_d;
      div_q      <= div_d;
      mode_q     <= mode_d;
      div_lim_q  <= div_lim_d;
      limit_q    <= limit_d;
    end
  end

  // Reset holds the state in StClear, so all outputs fall without waiting for a clock.
  always_comb begin
    bus.CntEnable  = (state_q == StRun) && div_hit && !at_limit && !bus.Stop;
    bus.CntClear_b = (state_q != StClear);
    bus.Busy       = (state_q == StRun) || ((state_q == StClear) && !rst_flag_q);
    bus.Done       = (state_q == StDone);
    bus.Wrap       = (state_q == StRun) && at_limit && !bus.Stop && !mode_q;
  end

endmodule

// File: tb/tb_counter_sequencer.sv
// Bench for counter_sequencer: directed scenarios plus random runs checked against
// an arithmetic per-cycle prediction of each run, with a behavioural counter attached.
module tb_counter_sequencer;

  logic Clock = 1'b0;
  logic Reset = 1'b1;
  logic [7:0] cv;
  int n_assert = 0;
  int n_fail = 0;

  counter_sequencer_if #(.DIV_W(8), .CNT_W(8)) bus ();

  counter_sequencer #(.DIV_W(8), .CNT_W(8)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clock = ~Clock;

  // Controlled counter: synchronous active-low clear, increment on enable.
  always_ff @(posedge Clock) begin
    if (!bus.CntClear_b) cv <= 8'd0;
    else if (bus.CntEnable) cv <= cv + 8'd1;
  end
  assign bus.CounterValue = cv;

  // {CntEnable, CntClear_b, Busy, Done, Wrap}
  function automatic logic [4:0] outs();
    return {bus.CntEnable, bus.CntClear_b, bus.Busy, bus.Done, bus.Wrap};
  endfunction

  localparam logic [4:0] OIdle  = 5'b01000;
  localparam logic [4:0] OClear = 5'b00100;
  localparam logic [4:0] ODone  = 5'b01010;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #2;
  endtask

  // One full run from IDLE. RUN cycle r (1-based) enables when r is a multiple of d+1,
  // and the terminal cycle is r = l*(d+1)+1 where the counter has reached l.
  task automatic run_seq(input bit m, input int d, input int l, input int periods);
    int t;
    bit exp_en;
    bit exp_wrap;
    t = l * (d + 1) + 1;
    bus.Mode  = m;
    bus.Div   = 8'(d);
    bus.Limit = 8'(l);
    bus.Stop  = 1'b0;
    bus.Start = 1'b1;
    tick();
    bus.Start = 1'b0;
    chk("start_clear", 32'(outs()), 32'(OClear));
    for (int p = 0; p < periods; p++) begin
      for (int r = 1; r <= t; r++) begin
        tick();
        exp_en   = (r % (d + 1) == 0) && (r < t);
        exp_wrap = (r == t) && !m;
        chk("run_outs", 32'(outs()), 32'({exp_en, 1'b1, 1'b1, 1'b0, exp_wrap}));
        chk("run_cv", 32'(cv), 32'((r - 1) / (d + 1)));
        // Shadowed inputs and Start must have no effect mid-run.
        bus.Start = 1'($urandom_range(0, 1));
        bus.Mode  = 1'($urandom_range(0, 1));
        bus.Div   = 8'($urandom);
        bus.Limit = 8'($urandom);
      end
      bus.Start = 1'b0;
      tick();
      if (m) begin
        chk("done_outs", 32'(outs()), 32'(ODone));
      end else begin
        chk("reload_clear", 32'(outs()), 32'(OClear));
      end
      chk("term_cv", 32'(cv), 32'(l));
    end
    if (m) begin
      tick();
      chk("post_done_idle", 32'(outs()), 32'(OIdle));
      chk("post_done_cv", 32'(cv), 32'(l));
    end else begin
      bus.Stop = 1'b1;
      tick();
      bus.Stop = 1'b0;
      chk("stop_in_clear_idle", 32'(outs()), 32'(OIdle));
      chk("stop_in_clear_cv", 32'(cv), 32'd0);
    end
  endtask

  initial begin
    #900us;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bus.Start = 1'b0;
    bus.Stop  = 1'b0;
    bus.Mode  = 1'b0;
    bus.Div   = 8'd0;
    bus.Limit = 8'd0;

    // Reset and release.
    repeat (2) @(posedge Clock);
    #2;
    chk("reset_outs", 32'(outs()), 32'd0);
    Reset = 1'b0;
    #1;
    chk("post_rst_clear_b", 32'(bus.CntClear_b), 32'd0);
    chk("post_rst_en", 32'(bus.CntEnable), 32'd0);
    tick();
    chk("post_rst_idle", 32'(outs()), 32'(OIdle));
    chk("post_rst_cv", 32'(cv), 32'd0);

    // One-shot, divider, auto-reload.
    run_seq(1'b1, 0, 3, 1);
    run_seq(1'b1, 4, 2, 1);
    run_seq(1'b0, 1, 2, 3);

    // Stop mid-run at CounterValue=5, Limit=9.
    bus.Mode = 1'b1; bus.Div = 8'd0; bus.Limit = 8'd9; bus.Start = 1'b1;
    tick();
    bus.Start = 1'b0;
    repeat (6) tick();
    chk("pre_stop_cv", 32'(cv), 32'd5);
    chk("pre_stop_en", 32'(bus.CntEnable), 32'd1);
    bus.Stop = 1'b1;
    #1;
    chk("stop_en_now", 32'(bus.CntEnable), 32'd0);
    tick();
    chk("stop_idle", 32'(outs()), 32'(OIdle));
    tick();
    chk("stop_cv_held", 32'(cv), 32'd5);

    // Start and Stop together in IDLE: no transition.
    bus.Start = 1'b1;
    tick();
    chk("start_stop_idle", 32'(outs()), 32'(OIdle));
    chk("start_stop_cv", 32'(cv), 32'd5);
    bus.Start = 1'b0;
    bus.Stop  = 1'b0;

    // Stop coincident with terminal: no Done, no Wrap.
    for (int mm = 0; mm < 2; mm++) begin
      bus.Mode = 1'(mm); bus.Div = 8'd0; bus.Limit = 8'd2; bus.Start = 1'b1;
      tick();
      bus.Start = 1'b0;
      repeat (3) tick();
      chk("term_cv_stop", 32'(cv), 32'd2);
      bus.Stop = 1'b1;
      #1;
      chk("term_stop_outs", 32'(outs()), 32'b01100);
      tick();
      bus.Stop = 1'b0;
      chk("term_stop_idle", 32'(outs()), 32'(OIdle));
      tick();
      chk("term_stop_no_done", 32'(outs()), 32'(OIdle));
    end

    // Asynchronous reset mid-run.
    bus.Mode = 1'b1; bus.Div = 8'd3; bus.Limit = 8'd10; bus.Start = 1'b1;
    tick();
    bus.Start = 1'b0;
    repeat (7) tick();
    chk("pre_reset_busy", 32'(bus.Busy), 32'd1);
    Reset = 1'b1;
    #1;
    chk("async_reset_outs", 32'(outs()), 32'd0);
    tick();
    chk("held_reset_outs", 32'(outs()), 32'd0);
    Reset = 1'b0;
    #1;
    chk("rel_clear_b", 32'(bus.CntClear_b), 32'd0);
    tick();
    chk("rel_idle", 32'(outs()), 32'(OIdle));
    chk("rel_cv", 32'(cv), 32'd0);

    // Limit=0 one-shot, then width boundaries.
    run_seq(1'b1, 3, 0, 1);
    run_seq(1'b1, 255, 2, 1);
    run_seq(1'b1, 0, 255, 1);

    // Random runs.
    for (int i = 0; i < 10; i++) begin
      bit m;
      m = 1'($urandom_range(0, 1));
      run_seq(m, int'($urandom_range(0, 7)), int'($urandom_range(0, 12)), m ? 1 : 2);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
